md_ctrl: RTL
============

MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5, the number of busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYC, default 10, the number of busy cycles for div/divu.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port start, input, 1 bit: an E-stage mult/div-family instruction is issued this cycle.
REQ-006 SHALL have port mdop, input, 3 bits: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 are no-op.
REQ-007 SHALL have port a, input, 32 bits: forwarded rs value.
REQ-008 SHALL have port b, input, 32 bits: forwarded rt value.
REQ-009 SHALL have port flush, input, 1 bit: exception/interrupt taken this cycle, so the E-stage start is cancelled.
REQ-010 SHALL have port d_ismd, input, 1 bit: the D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-011 SHALL have port stall, output, 1 bit: freeze PC/F/D and insert a bubble into E.
REQ-012 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-013 SHALL have ports hi and lo, outputs, 32 bits each: architectural HI/LO registers.

Function
REQ-014 SHALL implement two states, IDLE and RUN, plus a down-counter cnt of 4 bits minimum.
REQ-015 In IDLE, start=1 with flush=0 and mdop in {mult, multu, div, divu} SHALL latch the operands and load cnt with MULT_CYC or DIV_CYC, then enter RUN.
REQ-016 In RUN, busy SHALL be 1 and cnt SHALL decrement each cycle; on the edge where cnt reaches 1, HI/LO SHALL be written and the state returns to IDLE.
REQ-017 busy SHALL be 1 for exactly MULT_CYC (or DIV_CYC) consecutive cycles, starting the cycle after start.
REQ-018 mult SHALL be a signed 32x32 multiply; multu SHALL be unsigned; the 64-bit product goes to {hi, lo}.
REQ-019 div/divu SHALL write the quotient to lo and the remainder to hi; div truncates toward zero, with the remainder taking the sign of the dividend.
REQ-020 Divide by zero SHALL run the full DIV_CYC busy period but leave HI/LO unchanged.
REQ-021 div of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-022 mthi/mtlo with start=1 and flush=0 SHALL write a to hi/lo at the next edge, with busy staying 0.
REQ-023 start while in RUN SHALL be ignored (this is a protocol violation, prevented by stall).
REQ-024 start=1 with flush=1 SHALL be ignored; flush SHALL NOT abort an operation already in RUN.
REQ-025 stall SHALL equal d_ismd & (busy | (start & ~flush & mdop in {mult, multu, div, divu})) and SHALL be combinational.
REQ-026 hi/lo SHALL change only at a RUN completion edge or an mthi/mtlo edge.

Reset
REQ-027 reset=0 SHALL immediately force IDLE, cnt=0, busy=0, hi=0 and lo=0, independent of clk.
REQ-028 Reset asserted mid-RUN SHALL discard the operation and leave HI/LO at 0.
REQ-029 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-030 mdop encodings, the IDLE/RUN state encodings and the MULT_CYC/DIV_CYC defaults SHALL live in the shared definitions package md_pkg.
REQ-031 Arithmetic SHALL be a single combinational sub-module md_arith (inputs op, a, b; outputs hi_res, lo_res, dz).
REQ-032 md_arith SHALL be evaluated on the latched operands, and its results registered at completion.

Verification
REQ-033 mult with a=0xFFFFFFFE, b=3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-034 multu with a=0xFFFFFFFF, b=2 -> after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE.
REQ-035 div with a=-7 (0xFFFFFFF9), b=2 -> busy high for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu with b=0 -> HI/LO unchanged after 10 cycles.
REQ-036 mult issued, then d_ismd=1 (mflo in D) on the next cycle -> stall high in the issue cycle and all 5 busy cycles; stall low in the cycle after busy falls, with lo valid.
REQ-037 mtlo with a=0x12345678 and start=1, flush=1 -> lo unchanged; repeated with flush=0 -> lo=0x12345678 next cycle, busy never asserted.
REQ-038 reset pulsed low during cycle 3 of a div -> busy, hi and lo go to 0 at once, asynchronously; no write occurs at the original completion time.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the HI/LO multiply-divide unit.
// Opcode, state and latency constants used by md_ctrl and md_arith.
package md_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  // mult/multu/div/divu all occupy the unit
  function automatic logic is_long(
    input logic [2:0] op
  );
    return ~op[2];
  endfunction

  function automatic logic is_div(
    input logic [2:0] op
  );
    return ~op[2] & op[1];
  endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational 32x32 multiply and divide datapath.
// Results are only meaningful for mult/multu/div/divu opcodes.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        dz
);

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic [31:0] bd;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [31:0] mq;
  logic [31:0] mr;
  logic [31:0] uq;
  logic [31:0] ur;

  always_comb begin
    sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    uprod = {32'd0, a} * {32'd0, b};
    // divisor forced non-zero; dz suppresses the write anyway
    bd = (b == 32'd0) ? 32'd1 : b;
    ma = a[31] ? (~a + 32'd1) : a;
    mb = bd[31] ? (~bd + 32'd1) : bd;
    mq = ma / mb;
    mr = ma % mb;
    uq = a / bd;
    ur = a % bd;
  end

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    dz     = is_div(op) & (b == 32'd0);
    case (op)
      OP_MULT: begin
        hi_res = sprod[63:32];
        lo_res = sprod[31:0];
      end
      OP_MULTU: begin
        hi_res = uprod[63:32];
        lo_res = uprod[31:0];
      end
      OP_DIV: begin
        lo_res = (a[31] ^ bd[31]) ? (~mq + 32'd1) : mq;
        hi_res = a[31] ? (~mr + 32'd1) : mr;
      end
      OP_DIVU: begin
        lo_res = uq;
        hi_res = ur;
      end
      default: begin
        hi_res = '0;
        lo_res = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle HI/LO multiply-divide controller.
// Holds the pipeline via stall while an operation is in flight.
module md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        d_ismd,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CLG  = $clog2(MAXC + 1);
  localparam int CW   = (CLG > 4) ? CLG : 4;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [31:0]   hi_res;
  logic [31:0]   lo_res;
  logic          dz;
  logic          go;

  md_arith u_arith (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .dz     (dz)
  );

  assign go    = start & ~flush;
  assign busy  = (state == S_RUN);
  assign stall = d_ismd & (busy | (go & is_long(mdop)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (go && is_long(mdop)) begin
            state <= S_RUN;
            op_q  <= mdop;
            a_q   <= a;
            b_q   <= b;
            cnt   <= is_div(mdop) ? CW'(DIV_CYC)
                                  : CW'(MULT_CYC);
          end else if (go && mdop == OP_MTHI) begin
            hi <= a;
          end else if (go && mdop == OP_MTLO) begin
            lo <= a;
          end
        end
        (state == S_RUN): begin
          if (cnt == CW'(1)) begin
            state <= S_IDLE;
            cnt   <= '0;
            if (!dz) begin
              hi <= hi_res;
              lo <= lo_res;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
